// File: rtl/regfile_dump.sv
// Stalls the CPU on request and streams the current instruction word followed by
// registers FIRST_REG..LAST_REG over a valid/ready port.
module regfile_dump #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned NUM_REGS  = 32,
  parameter int unsigned FIRST_REG = 1,
  parameter int unsigned LAST_REG  = 5,
  localparam int unsigned AW       = $clog2(NUM_REGS)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            dump_req,
  output logic            cpu_halt,
  input  logic            halt_ack,
  input  logic [XLEN-1:0] inst_in,
  output logic [AW-1:0]   rf_raddr,
  input  logic [XLEN-1:0] rf_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic [AW-1:0]   out_index,
  output logic            out_is_inst,
  output logic            out_last,
  output logic            busy,
  output logic            dump_done
);

  typedef enum logic [2:0] {
    IDLE,
    HALT_WAIT,
    SEND,
    LOAD,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     reg_q, reg_d;
  logic [AW-1:0]     rf_raddr_q, rf_raddr_d;
  logic [XLEN-1:0]   out_data_q, out_data_d;
  logic [AW-1:0]     out_index_q, out_index_d;
  logic              out_valid_q, out_valid_d;
  logic              out_is_inst_q, out_is_inst_d;
  logic              out_last_q, out_last_d;
  logic              cpu_halt_q, cpu_halt_d;
  logic              busy_q, busy_d;
  logic              dump_done_q, dump_done_d;

  // State and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      reg_q         <= '0;
      rf_raddr_q    <= '0;
      out_data_q    <= '0;
      out_index_q   <= '0;
      out_valid_q   <= 1'b0;
      out_is_inst_q <= 1'b0;
      out_last_q    <= 1'b0;
      cpu_halt_q    <= 1'b0;
      busy_q        <= 1'b0;
      dump_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      reg_q         <= reg_d;
      rf_raddr_q    <= rf_raddr_d;
      out_data_q    <= out_data_d;
      out_index_q   <= out_index_d;
      out_valid_q   <= out_valid_d;
      out_is_inst_q <= out_is_inst_d;
      out_last_q    <= out_last_d;
      cpu_halt_q    <= cpu_halt_d;
      busy_q        <= busy_d;
      dump_done_q   <= dump_done_d;
    end
  end

  // Next state; beat fields hold unless loaded or handshaken
  always_comb begin
    state_d       = state_q;
    reg_d         = reg_q;
    out_data_d    = out_data_q;
    out_index_d   = out_index_q;
    out_valid_d   = out_valid_q;
    out_is_inst_d = out_is_inst_q;
    out_last_d    = out_last_q;

    case (state_q)
      IDLE: begin
        if (dump_req) state_d = HALT_WAIT;
      end
      HALT_WAIT: begin
        if (halt_ack) begin
          state_d       = SEND;
          out_data_d    = inst_in;
          out_index_d   = '0;
          out_is_inst_d = 1'b1;
          out_last_d    = 1'b0;
          out_valid_d   = 1'b1;
          reg_d         = AW'(FIRST_REG);
        end
      end
      SEND: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = out_last_q ? DONE : LOAD;
        end
      end
      LOAD: begin
        // x0 is architecturally zero whatever the read port returns
        out_data_d    = (rf_raddr_q == '0) ? '0 : rf_rdata;
        out_index_d   = rf_raddr_q;
        out_is_inst_d = 1'b0;
        out_last_d    = (rf_raddr_q == AW'(LAST_REG));
        out_valid_d   = 1'b1;
        reg_d         = reg_q + AW'(1);
        state_d       = SEND;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    cpu_halt_d  = (state_d != IDLE);
    busy_d      = (state_d != IDLE);
    dump_done_d = (state_d == DONE);
    rf_raddr_d  = (state_d == LOAD) ? reg_q : '0;
  end

  assign cpu_halt    = cpu_halt_q;
  assign busy        = busy_q;
  assign dump_done   = dump_done_q;
  assign rf_raddr    = rf_raddr_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_index   = out_index_q;
  assign out_is_inst = out_is_inst_q;
  assign out_last    = out_last_q;

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump: default dump, backpressure, late ack, single-x0 dump
// and reset mid-dump.
module tb_regfile_dump;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        dump_req, halt_ack, out_ready;
  logic [31:0] inst_in;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic        cpu_halt, out_valid, out_is_inst, out_last, busy, dump_done;
  logic [31:0] out_data;
  logic [4:0]  out_index;

  logic        req0, ack0, ready0;
  logic [4:0]  rf_raddr0;
  logic [31:0] rf_rdata0;
  logic        cpu_halt0, out_valid0, out_is_inst0, out_last0, busy0, dump_done0;
  logic [31:0] out_data0;
  logic [4:0]  out_index0;

  logic [31:0] rf [32];

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] cap_data[$];
  logic [4:0]  cap_idx[$];
  logic        cap_inst[$];
  logic        cap_last[$];
  logic [31:0] stall_data[$];
  logic [4:0]  stall_ix[$];
  int          done_pulses;
  bit          finished;

  always #5 clk = ~clk;

  assign rf_rdata  = rf[rf_raddr];
  assign rf_rdata0 = 32'hDEAD_BEEF;

  regfile_dump dut (
    .clk(clk), .reset_n(reset_n), .dump_req(dump_req), .cpu_halt(cpu_halt),
    .halt_ack(halt_ack), .inst_in(inst_in), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_is_inst(out_is_inst), .out_last(out_last),
    .busy(busy), .dump_done(dump_done)
  );

  regfile_dump #(.FIRST_REG(0), .LAST_REG(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .dump_req(req0), .cpu_halt(cpu_halt0),
    .halt_ack(ack0), .inst_in(inst_in), .rf_raddr(rf_raddr0), .rf_rdata(rf_rdata0),
    .out_valid(out_valid0), .out_ready(ready0), .out_data(out_data0),
    .out_index(out_index0), .out_is_inst(out_is_inst0), .out_last(out_last0),
    .busy(busy0), .dump_done(dump_done0)
  );

  // Request, then ack one cycle after cpu_halt rises; leaves the bench on the first beat
  task automatic start_dump();
    dump_req = 1'b1;
    @(negedge clk);
    dump_req = 1'b0;
    halt_ack = 1'b1;
    @(negedge clk);
    halt_ack = 1'b0;
  endtask

  // Accept beats until the dump finishes; optionally stall one register beat
  task automatic stream(input int stall_idx, input int stall_cycles);
    int stalls = 0;
    cap_data.delete(); cap_idx.delete(); cap_inst.delete(); cap_last.delete();
    stall_data.delete(); stall_ix.delete();
    done_pulses = 0;
    finished = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (dump_done) done_pulses++;
      if (out_valid) begin
        if (!out_is_inst && int'(out_index) == stall_idx && stalls < stall_cycles) begin
          out_ready = 1'b0;
          stalls++;
          stall_data.push_back(out_data);
          stall_ix.push_back(out_index);
        end else begin
          out_ready = 1'b1;
          cap_data.push_back(out_data);
          cap_idx.push_back(out_index);
          cap_inst.push_back(out_is_inst);
          cap_last.push_back(out_last);
        end
      end else begin
        out_ready = 1'b1;
      end
      if (done_pulses > 0 && !busy) begin
        finished = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if ({cpu_halt, out_valid, out_is_inst, out_last, busy, dump_done} !== 6'b0 ||
        out_data !== 32'h0 || out_index !== 5'h0 || rf_raddr !== 5'h0) begin
      miscompares++;
      $display("FAIL reset: flags=%b data=%h idx=%0d raddr=%0d, required all 0",
               {cpu_halt, out_valid, out_is_inst, out_last, busy, dump_done},
               out_data, out_index, rf_raddr);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || cpu_halt !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: busy=%b cpu_halt=%b, required 0 0", busy, cpu_halt);
    end
  endtask

  task automatic test_default_dump(input int stall_idx, input int stall_cycles, input string name);
    dump_req = 1'b1;
    @(negedge clk);
    dump_req = 1'b0;
    vectors++;
    if (cpu_halt !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_halt: cpu_halt=%b busy=%b valid=%b, required 1 1 0",
               name, cpu_halt, busy, out_valid);
    end
    halt_ack = 1'b1;
    @(negedge clk);
    halt_ack = 1'b0;
    stream(stall_idx, stall_cycles);
    vectors++;
    if (!finished || cap_data.size() != 6) begin
      miscompares++;
      $display("FAIL %s_count: finished=%b beats=%0d, required 1 6", name, finished, cap_data.size());
    end
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (i >= cap_data.size()) begin
        miscompares++;
        $display("FAIL %s_beat%0d: missing, required present", name, i);
      end else if (cap_data[i] !== ((i == 0) ? 32'h0050_0093 : 32'(i)) ||
                   cap_idx[i] !== 5'(i) || cap_inst[i] !== (i == 0) || cap_last[i] !== (i == 5)) begin
        miscompares++;
        $display("FAIL %s_beat%0d: data=%h idx=%0d inst=%b last=%b, required data=%h idx=%0d inst=%b last=%b",
                 name, i, cap_data[i], cap_idx[i], cap_inst[i], cap_last[i],
                 (i == 0) ? 32'h0050_0093 : 32'(i), i, i == 0, i == 5);
      end
    end
    vectors++;
    if (done_pulses != 1 || cpu_halt !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_done: pulses=%0d cpu_halt=%b, required 1 0", name, done_pulses, cpu_halt);
    end
  endtask

  task automatic test_backpressure();
    test_default_dump(2, 3, "bp");
    vectors++;
    if (stall_data.size() != 3) begin
      miscompares++;
      $display("FAIL bp_stalls: stalled cycles=%0d, required 3", stall_data.size());
    end
    for (int i = 0; i < stall_data.size(); i++) begin
      vectors++;
      if (stall_data[i] !== 32'd2 || stall_ix[i] !== 5'd2) begin
        miscompares++;
        $display("FAIL bp_hold%0d: data=%h idx=%0d, required 2 2", i, stall_data[i], stall_ix[i]);
      end
    end
  endtask

  task automatic test_late_ack();
    dump_req = 1'b1;
    @(negedge clk);
    dump_req = 1'b0;
    for (int c = 0; c < 4; c++) begin
      dump_req = (c == 1);
      vectors++;
      if (out_valid !== 1'b0 || cpu_halt !== 1'b1) begin
        miscompares++;
        $display("FAIL late_wait%0d: valid=%b cpu_halt=%b, required 0 1", c, out_valid, cpu_halt);
      end
      @(negedge clk);
    end
    dump_req = 1'b0;
    halt_ack = 1'b1;
    @(negedge clk);
    halt_ack = 1'b0;
    stream(-1, 0);
    vectors++;
    if (!finished || cap_data.size() != 6 || cap_inst[0] !== 1'b1 || cap_data[0] !== 32'h0050_0093) begin
      miscompares++;
      $display("FAIL late_dump: finished=%b beats=%0d first=%h, required 1 6 00500093",
               finished, cap_data.size(), (cap_data.size() > 0) ? cap_data[0] : 32'hx);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || cpu_halt !== 1'b0) begin
      miscompares++;
      $display("FAIL late_noqueue: busy=%b cpu_halt=%b, required 0 0", busy, cpu_halt);
    end
  endtask

  task automatic test_x0_only();
    ready0 = 1'b1;
    req0 = 1'b1;
    @(negedge clk);
    req0 = 1'b0;
    ack0 = 1'b1;
    @(negedge clk);
    ack0 = 1'b0;
    vectors++;
    if (out_valid0 !== 1'b1 || out_is_inst0 !== 1'b1 || out_data0 !== 32'h0050_0093 ||
        out_index0 !== 5'd0 || out_last0 !== 1'b0) begin
      miscompares++;
      $display("FAIL x0_inst: valid=%b inst=%b data=%h idx=%0d last=%b, required 1 1 00500093 0 0",
               out_valid0, out_is_inst0, out_data0, out_index0, out_last0);
    end
    @(negedge clk);
    vectors++;
    if (out_valid0 !== 1'b0) begin
      miscompares++;
      $display("FAIL x0_bubble: valid=%b, required 0", out_valid0);
    end
    @(negedge clk);
    vectors++;
    if (out_valid0 !== 1'b1 || out_is_inst0 !== 1'b0 || out_data0 !== 32'h0 ||
        out_index0 !== 5'd0 || out_last0 !== 1'b1) begin
      miscompares++;
      $display("FAIL x0_reg: valid=%b inst=%b data=%h idx=%0d last=%b, required 1 0 00000000 0 1",
               out_valid0, out_is_inst0, out_data0, out_index0, out_last0);
    end
    @(negedge clk);
    vectors++;
    if (dump_done0 !== 1'b1 || out_valid0 !== 1'b0) begin
      miscompares++;
      $display("FAIL x0_done: done=%b valid=%b, required 1 0", dump_done0, out_valid0);
    end
    @(negedge clk);
    vectors++;
    if (busy0 !== 1'b0 || cpu_halt0 !== 1'b0 || dump_done0 !== 1'b0) begin
      miscompares++;
      $display("FAIL x0_idle: busy=%b cpu_halt=%b done=%b, required 0 0 0", busy0, cpu_halt0, dump_done0);
    end
  endtask

  task automatic test_reset_mid_dump();
    bit found = 1'b0;
    out_ready = 1'b1;
    start_dump();
    for (int c = 0; c < 40; c++) begin
      if (out_valid && out_index == 5'd3 && !out_is_inst) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL rst_mid_find: x3 beat seen=%b, required 1", found);
    end
    out_ready = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if (cpu_halt !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid: cpu_halt=%b valid=%b busy=%b, required 0 0 0", cpu_halt, out_valid, busy);
    end
    @(negedge clk);
    reset_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    test_default_dump(-1, 0, "after_rst");
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = (i >= 1 && i <= 5) ? 32'(i) : (32'hA5A5_0000 | 32'(i));
    reset_n   = 1'b1;
    dump_req  = 1'b0;
    halt_ack  = 1'b0;
    out_ready = 1'b1;
    inst_in   = 32'h0050_0093;
    req0      = 1'b0;
    ack0      = 1'b0;
    ready0    = 1'b1;

    test_reset();
    test_default_dump(-1, 0, "default");
    test_backpressure();
    test_late_ack();
    test_x0_only();
    test_reset_mid_dump();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
